// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified 8-bit RAM/IO port controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Requester identity; also the bit index into request/grant vectors.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_e;

  // LSB op field layout: [2] store, [1:0] access size.
  localparam int          OP_STORE_BIT = 2;
  localparam logic [1:0]  SZ_BYTE      = 2'b00;
  localparam logic [1:0]  SZ_HALF      = 2'b01;
  localparam logic [1:0]  SZ_WORD      = 2'b11;

  // addr[17:16] value that selects the IO space.
  localparam logic [1:0]  IO_SEL_DEF   = 2'b11;

  // Number of byte cycles for a size code; unused code 10 falls back to a byte.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_WORD: size_bytes = 3'd4;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last.
import mem_ctrl_pkg::*;

module mem_rr_arbiter (
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from masked requests and the previous winner.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OWN_IF) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller owning the 8-bit RAM/IO port. Serialises instruction
// fetches and LSB loads/stores into byte cycles, arbitrating round-robin.
import mem_ctrl_pkg::*;

module mem_ctrl #(
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        ioBufferFull,
  input  logic        ifFlag,
  input  logic [31:0] ifAddr,
  output logic        ifOkFlag,
  output logic [31:0] ifData,
  input  logic        lsbFlag,
  input  logic [2:0]  lsbOp,
  input  logic [31:0] lsbAddr,
  input  logic [31:0] lsbDataIn,
  output logic        lsbOkFlag,
  output logic [31:0] lsbDataOut,
  input  logic [7:0]  memDin,
  output logic [7:0]  memDout,
  output logic [31:0] memA,
  output logic        memWr
);

  state_e      state_q;
  owner_e      owner_q;     // current owner; doubles as lastGrant
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  nb_q;        // bytes in this access
  logic [2:0]  cnt_q;       // byte cycle index
  logic [31:0] res_q;       // read bytes assembled so far
  logic [31:0] res_d;
  logic        ifOk_q, lsbOk_q;
  logic [31:0] ifData_q, lsbData_q;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        lsb_store;
  logic        io_stall;
  logic [31:0] cur_addr;
  logic [31:0] data_sh;

  assign lsb_store = lsbOp[OP_STORE_BIT];

  // A requester seeing its ok pulse is finishing, not asking again.
  // Flush suppresses fetches and loads; stores must still drain.
  assign req[OWN_IF]  = ifFlag  && !ifOk_q  && !clearIn;
  assign req[OWN_LSB] = lsbFlag && !lsbOk_q && (lsb_store || !clearIn);

  mem_rr_arbiter u_arb (
    .req_i  (req),
    .last_i (owner_q),
    .gnt_o  (gnt)
  );

  assign cur_addr = addr_q + {29'd0, cnt_q};
  assign data_sh  = data_q >> {cnt_q[1:0], 3'b000};
  assign io_stall = (addr_q[17:16] == IO_SEL) && ioBufferFull;

  // Bus drive decoded from state; the drain cycle of a read issues no address.
  always_comb begin
    memA    = 32'd0;
    memDout = 8'd0;
    memWr   = 1'b0;
    if (state_q == ST_READ && cnt_q < nb_q) begin
      memA = cur_addr;
    end else if (state_q == ST_WRITE) begin
      memA    = cur_addr;
      memDout = data_sh[7:0];
      memWr   = readyIn && !io_stall;
    end
  end

  // Byte returned for address cycle cnt-1 lands in its little-endian slot.
  always_comb begin
    res_d = res_q;
    if (state_q == ST_READ) begin
      case (cnt_q)
        3'd1:    res_d[7:0]   = memDin;
        3'd2:    res_d[15:8]  = memDin;
        3'd3:    res_d[23:16] = memDin;
        3'd4:    res_d[31:24] = memDin;
        default: res_d = res_q;
      endcase
    end
  end

  // Controller FSM: grant, byte sequencing and registered result/ok outputs.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      nb_q      <= 3'd0;
      cnt_q     <= 3'd0;
      res_q     <= 32'd0;
      ifOk_q    <= 1'b0;
      lsbOk_q   <= 1'b0;
      ifData_q  <= 32'd0;
      lsbData_q <= 32'd0;
    end else if (readyIn) begin
      ifOk_q  <= 1'b0;
      lsbOk_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            owner_q <= gnt[OWN_LSB] ? OWN_LSB : OWN_IF;
            addr_q  <= gnt[OWN_LSB] ? lsbAddr : ifAddr;
            data_q  <= lsbDataIn;
            nb_q    <= gnt[OWN_LSB] ? size_bytes(lsbOp[1:0]) : 3'd4;
            cnt_q   <= 3'd0;
            res_q   <= 32'd0;
            state_q <= (gnt[OWN_LSB] && lsb_store) ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (clearIn) begin
            state_q <= ST_IDLE;
          end else begin
            res_q <= res_d;
            if (cnt_q == nb_q) begin
              state_q <= ST_IDLE;
              if (owner_q == OWN_IF) begin
                ifOk_q   <= 1'b1;
                ifData_q <= res_d;
              end else begin
                lsbOk_q   <= 1'b1;
                lsbData_q <= res_d;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (cnt_q == nb_q - 3'd1) begin
              state_q <= ST_IDLE;
              lsbOk_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ifOkFlag   = ifOk_q;
  assign ifData     = ifData_q;
  assign lsbOkFlag  = lsbOk_q;
  assign lsbDataOut = lsbData_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_ctrl;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        readyIn = 1'b1;
  logic        clearIn = 1'b0;
  logic        ioBufferFull = 1'b0;
  logic        ifFlag = 1'b0;
  logic [31:0] ifAddr = 32'd0;
  logic        lsbFlag = 1'b0;
  logic [2:0]  lsbOp = 3'd0;
  logic [31:0] lsbAddr = 32'd0;
  logic [31:0] lsbDataIn = 32'd0;
  logic [7:0]  memDin;
  logic        ifOkFlag, lsbOkFlag, memWr;
  logic [31:0] ifData, lsbDataOut, memA;
  logic [7:0]  memDout;

  int vec = 0;
  int err = 0;

  mem_ctrl dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .ioBufferFull(ioBufferFull),
    .ifFlag(ifFlag), .ifAddr(ifAddr), .ifOkFlag(ifOkFlag), .ifData(ifData),
    .lsbFlag(lsbFlag), .lsbOp(lsbOp), .lsbAddr(lsbAddr), .lsbDataIn(lsbDataIn),
    .lsbOkFlag(lsbOkFlag), .lsbDataOut(lsbDataOut),
    .memDin(memDin), .memDout(memDout), .memA(memA), .memWr(memWr)
  );

  always #5 clockIn = ~clockIn;

  // Read-only RAM image; reads return one cycle after the address.
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h100: rom_byte = 8'h13;
      32'h101: rom_byte = 8'h05;
      32'h203: rom_byte = 8'h80;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  always @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) memDin <= 8'h00;
    else          memDin <= rom_byte(memA);
  end

  task automatic next_cycle;
    @(posedge clockIn);
    #1;
  endtask

  task automatic test_reset;
    #2;
    vec++;
    if ({memWr, memA, memDout} !== 41'd0) begin
      err++; $display("FAIL reset_bus: memWr=%b memA=%h memDout=%h, want 0/0/0", memWr, memA, memDout);
    end
    vec++;
    if ({ifOkFlag, lsbOkFlag, ifData, lsbDataOut} !== 66'd0) begin
      err++; $display("FAIL reset_out: ifOk=%b lsbOk=%b ifData=%h lsbData=%h, want all 0", ifOkFlag, lsbOkFlag, ifData, lsbDataOut);
    end
    next_cycle; next_cycle;
    resetIn = 1'b1;
    next_cycle;
  endtask

  task automatic test_if_fetch;
    next_cycle; ifAddr = 32'h100; ifFlag = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle;
      if (c == 7) ifFlag = 1'b0;
      @(negedge clockIn);
      if (c <= 4) begin
        vec++;
        if (memA !== 32'h100 + c - 1 || memWr !== 1'b0) begin
          err++; $display("FAIL fetch_addr c%0d: memA=%h memWr=%b, want %h/0", c, memA, memWr, 32'h100 + c - 1);
        end
      end
      vec++;
      if (ifOkFlag !== (c == 6)) begin
        err++; $display("FAIL fetch_ok c%0d: ifOkFlag=%b, want %b", c, ifOkFlag, c == 6);
      end
      if (c == 6) begin
        vec++;
        if (ifData !== 32'h00000513) begin
          err++; $display("FAIL fetch_data: ifData=%h, want 00000513", ifData);
        end
      end
    end
  endtask

  task automatic test_byte_load;
    next_cycle; lsbAddr = 32'h203; lsbOp = 3'b000; lsbFlag = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle;
      if (c == 4) lsbFlag = 1'b0;
      @(negedge clockIn);
      if (c <= 2) begin
        vec++;
        if (memA !== ((c == 1) ? 32'h203 : 32'h0)) begin
          err++; $display("FAIL lb_addr c%0d: memA=%h, want %h", c, memA, (c == 1) ? 32'h203 : 32'h0);
        end
      end
      vec++;
      if (lsbOkFlag !== (c == 3)) begin
        err++; $display("FAIL lb_ok c%0d: lsbOkFlag=%b, want %b", c, lsbOkFlag, c == 3);
      end
      if (c == 3) begin
        vec++;
        if (lsbDataOut !== 32'h00000080) begin
          err++; $display("FAIL lb_data: lsbDataOut=%h, want 00000080", lsbDataOut);
        end
      end
    end
  endtask

  task automatic test_half_store;
    logic got;
    next_cycle; lsbAddr = 32'h10; lsbOp = 3'b101; lsbDataIn = 32'h1234BEEF; lsbFlag = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle;
      if (c == 1) begin ifAddr = 32'h100; ifFlag = 1'b1; end
      if (c == 4) lsbFlag = 1'b0;
      @(negedge clockIn);
      case (c)
        1: begin
          vec++;
          if (memWr !== 1'b1 || memA !== 32'h10 || memDout !== 8'hEF) begin
            err++; $display("FAIL sh_b0: wr=%b a=%h d=%h, want 1/10/ef", memWr, memA, memDout);
          end
        end
        2: begin
          vec++;
          if (memWr !== 1'b1 || memA !== 32'h11 || memDout !== 8'hBE) begin
            err++; $display("FAIL sh_b1: wr=%b a=%h d=%h, want 1/11/be", memWr, memA, memDout);
          end
        end
        3: begin
          vec++;
          if (lsbOkFlag !== 1'b1 || memWr !== 1'b0 || memA !== 32'h0) begin
            err++; $display("FAIL sh_done: lsbOk=%b wr=%b a=%h, want 1/0/0", lsbOkFlag, memWr, memA);
          end
        end
        default: begin
          vec++;
          if (memA !== 32'h100 || memWr !== 1'b0) begin
            err++; $display("FAIL sh_if_after: memA=%h wr=%b, want 100/0", memA, memWr);
          end
        end
      endcase
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      next_cycle;
      @(negedge clockIn);
      if (ifOkFlag) got = 1'b1;
    end
    vec++;
    if (!got) begin
      err++; $display("FAIL sh_if_timeout: ifOkFlag=0, want 1 within 10 cycles");
    end
    next_cycle; ifFlag = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [3:0] order;
    n = 0; order = 4'd0;
    next_cycle;
    ifAddr = 32'h100; lsbAddr = 32'h203; lsbOp = 3'b000;
    ifFlag = 1'b1; lsbFlag = 1'b1;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      next_cycle;
      @(negedge clockIn);
      if (ifOkFlag && n < 4) begin
        order[n] = 1'b0; n++;
        vec++;
        if (ifData !== 32'h00000513) begin
          err++; $display("FAIL rr_ifdata: ifData=%h, want 00000513", ifData);
        end
      end
      if (lsbOkFlag && n < 4) begin
        order[n] = 1'b1; n++;
        vec++;
        if (lsbDataOut !== 32'h00000080) begin
          err++; $display("FAIL rr_lsbdata: lsbDataOut=%h, want 00000080", lsbDataOut);
        end
      end
    end
    vec++;
    if (n != 4 || order !== 4'b0101) begin
      err++; $display("FAIL rr_order: pulses=%0d order=%b, want 4 / 0101 (LSB,IF,LSB,IF)", n, order);
    end
    next_cycle; ifFlag = 1'b0; lsbFlag = 1'b0;
    repeat (12) next_cycle;
  endtask

  task automatic test_io_stall;
    next_cycle;
    lsbAddr = 32'h30000; lsbOp = 3'b111; lsbDataIn = 32'h41; lsbFlag = 1'b1; ioBufferFull = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle;
      if (c == 4) ioBufferFull = 1'b0;
      if (c == 9) lsbFlag = 1'b0;
      @(negedge clockIn);
      if (c <= 3) begin
        vec++;
        if (memWr !== 1'b0 || memA !== 32'h30000) begin
          err++; $display("FAIL io_stall c%0d: wr=%b a=%h, want 0/30000", c, memWr, memA);
        end
      end else if (c <= 7) begin
        vec++;
        if (memWr !== 1'b1 || memA !== 32'h30000 + c - 4 || memDout !== ((c == 4) ? 8'h41 : 8'h00)) begin
          err++; $display("FAIL io_write c%0d: wr=%b a=%h d=%h, want 1/%h/%h", c, memWr, memA, memDout,
                          32'h30000 + c - 4, (c == 4) ? 8'h41 : 8'h00);
        end
      end
      vec++;
      if (lsbOkFlag !== (c == 8)) begin
        err++; $display("FAIL io_ok c%0d: lsbOkFlag=%b, want %b", c, lsbOkFlag, c == 8);
      end
    end
  endtask

  task automatic test_clear;
    logic [31:0] d;
    logic [31:0] e;
    // flush during a fetch
    next_cycle; ifAddr = 32'h100; ifFlag = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle;
      if (c == 2) clearIn = 1'b1;
      if (c == 3) begin clearIn = 1'b0; ifFlag = 1'b0; end
      @(negedge clockIn);
      if (c == 3) begin
        vec++;
        if (memA !== 32'h0) begin
          err++; $display("FAIL clr_rd_idle: memA=%h, want 0", memA);
        end
      end
      vec++;
      if (ifOkFlag !== 1'b0) begin
        err++; $display("FAIL clr_rd_ok c%0d: ifOkFlag=%b, want 0", c, ifOkFlag);
      end
    end
    // flush held across a word store, including its grant cycle
    d = 32'hDDCCBBAA;
    next_cycle;
    lsbAddr = 32'h40; lsbOp = 3'b111; lsbDataIn = d; lsbFlag = 1'b1; clearIn = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle;
      if (c == 4) clearIn = 1'b0;
      if (c == 6) lsbFlag = 1'b0;
      @(negedge clockIn);
      if (c <= 4) begin
        e = d >> (8 * (c - 1));
        vec++;
        if (memWr !== 1'b1 || memA !== 32'h40 + c - 1 || memDout !== e[7:0]) begin
          err++; $display("FAIL clr_wr c%0d: wr=%b a=%h d=%h, want 1/%h/%h", c, memWr, memA, memDout,
                          32'h40 + c - 1, e[7:0]);
        end
      end
      if (c == 5) begin
        vec++;
        if (lsbOkFlag !== 1'b1) begin
          err++; $display("FAIL clr_wr_ok: lsbOkFlag=%b, want 1", lsbOkFlag);
        end
      end
    end
  endtask

  task automatic test_ready;
    next_cycle; lsbAddr = 32'h203; lsbOp = 3'b000; lsbFlag = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle;
      if (c == 1) readyIn = 1'b0;
      if (c == 3) readyIn = 1'b1;
      if (c == 6) lsbFlag = 1'b0;
      @(negedge clockIn);
      if (c <= 4) begin
        vec++;
        if (memA !== ((c <= 3) ? 32'h203 : 32'h0)) begin
          err++; $display("FAIL rdy_addr c%0d: memA=%h, want %h", c, memA, (c <= 3) ? 32'h203 : 32'h0);
        end
      end
      vec++;
      if (lsbOkFlag !== (c == 5)) begin
        err++; $display("FAIL rdy_ok c%0d: lsbOkFlag=%b, want %b", c, lsbOkFlag, c == 5);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    next_cycle; ifAddr = 32'h100; ifFlag = 1'b1;
    next_cycle;
    @(negedge clockIn);
    vec++;
    if (memA !== 32'h100) begin
      err++; $display("FAIL rst_pre: memA=%h, want 100", memA);
    end
    next_cycle;
    resetIn = 1'b0;
    #1;
    vec++;
    if ({memWr, memA, memDout, ifOkFlag, lsbOkFlag} !== 43'd0) begin
      err++; $display("FAIL rst_mid_bus: wr=%b a=%h d=%h ifOk=%b lsbOk=%b, want all 0", memWr, memA, memDout, ifOkFlag, lsbOkFlag);
    end
    vec++;
    if (ifData !== 32'h0 || lsbDataOut !== 32'h0) begin
      err++; $display("FAIL rst_mid_data: ifData=%h lsbData=%h, want 0/0", ifData, lsbDataOut);
    end
    ifFlag = 1'b0;
    next_cycle; next_cycle;
    resetIn = 1'b1;
    next_cycle;
  endtask

  initial begin
    test_reset;
    test_if_fetch;
    test_byte_load;
    test_half_store;
    test_back_to_back;
    test_io_stall;
    test_clear;
    test_ready;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole owner of the 8-bit unified RAM/IO port; serves the instruction fetcher (word reads) and the load/store buffer (byte/half/word loads and stores).
- Arbitrates round-robin between the two requesters and serialises each access into byte cycles.
- Assembles and splits data; stalls stores to IO while the UART buffer is full.
- Honours the pipeline flush (clearIn) by aborting reads only; writes always complete.

Parameters:
IO_SEL, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
clockIn  in  1  sole clock, rising edge
resetIn  in  1  asynchronous, active-low reset
readyIn  in  1  global enable; low freezes all state
clearIn  in  1  flush on branch mispredict; aborts in-flight or pending reads
ioBufferFull  in  1  IO output buffer full; blocks IO writes
ifFlag  in  1  fetch request, level, held until ifOkFlag
ifAddr  in  32  fetch byte address
ifOkFlag  out  1  one-cycle pulse; ifData valid
ifData  out  32  fetched word, little-endian
lsbFlag  in  1  LSB request, level, held until lsbOkFlag
lsbOp  in  3  [2]=store, [1:0]: 00 byte, 01 half, 11 word
lsbAddr  in  32  load/store byte address
lsbDataIn  in  32  store data (low bytes used)
lsbOkFlag  out  1  one-cycle pulse; load data valid or store done
lsbDataOut  out  32  load data, zero-extended raw bytes (LSB sign-extends)
memDin  in  8  RAM/IO read byte, valid one cycle after address
memDout  out  8  write byte
memA  out  32  byte address
memWr  out  1  1 = write

Behaviour:
- Reset (resetIn low, async): state IDLE, memWr=0, memA=0, memDout=0, ifOkFlag=0, lsbOkFlag=0, ifData=0, lsbDataOut=0, lastGrant=IF.
- States: IDLE, READ, WRITE.
- Byte count n: 1, 2 or 4 from op[1:0] (11 -> 4). Fetch always uses n=4.
- readyIn=0: no state, counter or output register changes; memWr forced 0.
- IDLE arbitration:
  - A requester whose ok flag is high this cycle is treated as not requesting.
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to lastGrant.
  - On grant: latch addr, op, data and owner; clear counter; go to READ, or to WRITE for an LSB store.
  - With clearIn high, ifFlag and LSB loads are ignored; LSB stores may still be granted.
- READ:
  - Cycle k (k=0..n-1) drives memA=base+k, memWr=0.
  - Byte k arrives on memDin in cycle k+1 and is placed in result[8k+7:8k].
  - Cycle n is drain only: no address issued, last byte captured.
  - At that edge, set the owner's ok flag, set its data output (upper bytes 0), return to IDLE.
  - Word load: request in c0, okFlag high in c6.
- WRITE:
  - Cycle k drives memA=base+k, memDout=data[8k+7:8k], memWr=1.
  - IO stall: if addr[17:16]==IO_SEL and ioBufferFull=1, drive memWr=0 and do not advance.
  - After byte n-1 is written: lsbOkFlag pulses next cycle, return to IDLE.
  - Word store with no stall: ok in c5.
- Ok flags are single-cycle: cleared on the next readyIn edge.
- clearIn during READ: return to IDLE at that edge, no ok pulse, partial data discarded.
- clearIn during WRITE: ignored; the store runs to completion and pulses lsbOkFlag.
- Address arithmetic is base+k modulo 2^32; no alignment check (misaligned accesses are legal byte sequences).
- lastGrant updates on every grant.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state enum: IDLE, READ, WRITE
  - owner encoding: IF, LSB
  - op field positions and size codes: 00, 01, 11
  - IO_SEL default
- One natural sub-module, mem_rr_arbiter: 2-way round-robin, taking masked requests and lastGrant and producing a one-hot grant.
- Byte sequencing stays in mem_ctrl.

Test Plan:
1. IF only: ifAddr=0x100, RAM bytes 13,05,00,00 -> memA 0x100..0x103 in c1..c4; ifOkFlag in c6 with ifData=0x00000513.
2. LSB byte load at 0x203, RAM[0x203]=0x80 -> single address cycle; lsbOkFlag in c3 with lsbDataOut=0x00000080.
3. LSB half store 0xBEEF to 0x10 -> memWr=1 with (0x10,EF) then (0x11,BE); lsbOkFlag next cycle; no IF grant in between.
4. ifFlag and lsbFlag both held continuously -> grants alternate LSB, IF, LSB…; neither waits more than one transaction.
5. Word store 0x41 to 0x30000, ioBufferFull=1 for 3 cycles -> memWr=0 for those cycles, byte 0 written after release, all 4 bytes written in order, single lsbOkFlag.
6. clearIn mid word fetch (c2) -> IDLE next cycle, no ifOkFlag. clearIn mid word store -> store completes and lsbOkFlag pulses. resetIn low mid-read -> all outputs 0 immediately.
